// File: rtl/gdma_cmd_sched.sv
// Burst command scheduler: captures per-requester DMA jobs, splits them into
// MAX_BURST-aligned bursts and round-robins them onto a single command port.
module gdma_cmd_sched #(
  parameter int MAX_BURST = 256,
  localparam int OW = $clog2(MAX_BURST),
  localparam int LW = OW + 1
) (
  input  logic            zynq2gdma_reg_clk,
  input  logic            zynq2gdma_reg_rst_n,
  input  logic [7:0]      req_start,
  input  logic [8*49-1:0] req_addr,
  input  logic [8*32-1:0] req_len,
  input  logic [31:0]     speed_divider,
  input  logic            flush,
  output logic            cmd_valid,
  input  logic            cmd_ready,
  output logic [2:0]      cmd_id,
  output logic [48:0]     cmd_addr,
  output logic [LW-1:0]   cmd_len,
  output logic            cmd_last,
  output logic [7:0]      busy,
  output logic [7:0]      done
);

  typedef enum logic [1:0] {IDLE, ARB, ISSUE, GAP} state_t;

  state_t        state_q, state_d;
  logic [7:0]    start_d_q;
  logic [7:0]    busy_q, busy_d;
  logic [7:0]    done_q, done_d;
  logic [48:0]   addr_q [8];
  logic [48:0]   addr_d [8];
  logic [31:0]   rem_q [8];
  logic [31:0]   rem_d [8];
  logic [2:0]    rr_q, rr_d;
  logic [2:0]    grant_q, grant_d;
  logic [48:0]   cmd_addr_q, cmd_addr_d;
  logic [LW-1:0] cmd_len_q, cmd_len_d;
  logic          cmd_last_q, cmd_last_d;
  logic [31:0]   gap_q, gap_d;
  logic          flush_pend_q, flush_pend_d;

  logic          accept;
  logic          flush_now;
  logic          load;
  logic [7:0]    start_rise;
  logic [2:0]    nxt_grant;
  logic [LW-1:0] nxt_size;

  // First requesting index at or after ptr, wrapping 7 -> 0.
  function automatic logic [2:0] pick(input logic [7:0] req, input logic [2:0] ptr);
    logic [2:0] idx;
    logic       found;
    pick  = ptr;
    found = 1'b0;
    for (int k = 0; k < 8; k++) begin
      idx = ptr + 3'(k);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  endfunction

  function automatic logic [LW-1:0] burst_size(input logic [48:0] a, input logic [31:0] rem);
    logic [31:0] room;
    room = 32'(MAX_BURST) - 32'(a[OW-1:0]);
    burst_size = (rem < room) ? rem[LW-1:0] : room[LW-1:0];
  endfunction

  assign accept     = (state_q == ISSUE) && cmd_ready;
  assign start_rise = req_start & ~start_d_q & ~busy_q;
  // A flush seen during ISSUE is held until the handshake so cmd_valid never drops early.
  assign flush_now  = (flush && (state_q != ISSUE)) ||
                      (accept && (flush || flush_pend_q));

  always_comb begin
    state_d      = state_q;
    busy_d       = busy_q;
    done_d       = '0;
    addr_d       = addr_q;
    rem_d        = rem_q;
    rr_d         = rr_q;
    grant_d      = grant_q;
    cmd_addr_d   = cmd_addr_q;
    cmd_len_d    = cmd_len_q;
    cmd_last_d   = cmd_last_q;
    gap_d        = gap_q;
    flush_pend_d = flush_pend_q;
    load         = 1'b0;

    if (accept) begin
      addr_d[grant_q] = addr_q[grant_q] + 49'(cmd_len_q);
      rem_d[grant_q]  = rem_q[grant_q] - 32'(cmd_len_q);
      rr_d            = grant_q + 3'd1;
      if (cmd_last_q) begin
        busy_d[grant_q] = 1'b0;
        done_d[grant_q] = 1'b1;
      end
    end

    for (int i = 0; i < 8; i++) begin
      if (start_rise[i]) begin
        if (req_len[32*i +: 32] == 32'd0) begin
          done_d[i] = 1'b1;
        end else begin
          busy_d[i] = 1'b1;
          addr_d[i] = req_addr[49*i +: 49];
          rem_d[i]  = req_len[32*i +: 32];
        end
      end
    end

    if (flush_now) begin
      busy_d       = '0;
      done_d       = '0;
      flush_pend_d = 1'b0;
    end else if ((state_q == ISSUE) && flush) begin
      flush_pend_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (!flush_now && (busy_d != 8'd0)) state_d = ARB;
      end
      ARB: begin
        if (flush_now || (busy_d == 8'd0)) begin
          state_d = IDLE;
        end else begin
          load    = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (accept) begin
          if (flush_now) begin
            state_d = IDLE;
          end else if (speed_divider != 32'd0) begin
            gap_d   = speed_divider;
            state_d = GAP;
          end else if (busy_d != 8'd0) begin
            load    = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      GAP: begin
        if (flush_now) begin
          state_d = IDLE;
        end else if (gap_q <= 32'd1) begin
          if (busy_d != 8'd0) begin
            load    = 1'b1;
            state_d = ISSUE;
          end else begin
            state_d = IDLE;
          end
        end else begin
          gap_d = gap_q - 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Arbitrate on post-update state so consecutive bursts can issue without a bubble.
    nxt_grant = pick(busy_d, rr_d);
    nxt_size  = burst_size(addr_d[nxt_grant], rem_d[nxt_grant]);
    if (load) begin
      grant_d    = nxt_grant;
      cmd_addr_d = addr_d[nxt_grant];
      cmd_len_d  = nxt_size;
      cmd_last_d = (32'(nxt_size) == rem_d[nxt_grant]);
    end
  end

  // Start history resets high so a start level held across reset is not an edge.
  always_ff @(posedge zynq2gdma_reg_clk or negedge zynq2gdma_reg_rst_n) begin
    if (!zynq2gdma_reg_rst_n) begin
      state_q      <= IDLE;
      start_d_q    <= '1;
      busy_q       <= '0;
      done_q       <= '0;
      rr_q         <= '0;
      grant_q      <= '0;
      cmd_addr_q   <= '0;
      cmd_len_q    <= '0;
      cmd_last_q   <= 1'b0;
      gap_q        <= '0;
      flush_pend_q <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        addr_q[i] <= '0;
        rem_q[i]  <= '0;
      end
    end else begin
      state_q      <= state_d;
      start_d_q    <= req_start;
      busy_q       <= busy_d;
      done_q       <= done_d;
      rr_q         <= rr_d;
      grant_q      <= grant_d;
      cmd_addr_q   <= cmd_addr_d;
      cmd_len_q    <= cmd_len_d;
      cmd_last_q   <= cmd_last_d;
      gap_q        <= gap_d;
      flush_pend_q <= flush_pend_d;
      for (int i = 0; i < 8; i++) begin
        addr_q[i] <= addr_d[i];
        rem_q[i]  <= rem_d[i];
      end
    end
  end

  assign cmd_valid = (state_q == ISSUE);
  assign cmd_id    = grant_q;
  assign cmd_addr  = cmd_addr_q;
  assign cmd_len   = cmd_len_q;
  assign cmd_last  = cmd_last_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
